// File: rtl/cnt_sched_pkg.sv
// Shared types and default sizing for the counter scheduler.
// The FSM state encoding lives here so the arbiter and top agree on it.
package cnt_sched_pkg;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer,
// wrapping modulo N_REQ.
module rr_arbiter
    import cnt_sched_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] pointer,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] index
);

    // Scan offsets from farthest to nearest so the closest requester wins.
    always_comb begin
        index = pointer;
        grant = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin : scan
            int pos;
            logic [IDX_W-1:0] sel;
            pos = int'(pointer) + k;
            if (pos >= N_REQ) begin
                pos = pos - N_REQ;
            end
            sel = IDX_W'(pos);
            if (req[sel]) begin
                index      = sel;
                grant      = '0;
                grant[sel] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cnt_sched.sv
// Round-robin scheduler sharing one loadable up-counter between N_REQ
// requesters; acks each granted interval once the counter reaches its length.
module cnt_sched
    import cnt_sched_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] req_len,
    input  logic                   abort,
    output logic [N_REQ-1:0]       ack,
    output logic [N_REQ-1:0]       gnt,
    output logic                   busy,
    output logic                   err,
    output logic                   ld_enb,
    output logic [WIDTH-1:0]       data_in,
    output logic                   count_enb,
    input  logic [WIDTH-1:0]       count_out
);

    localparam int IDX_W = $clog2(N_REQ);

    state_t           state, state_next;
    logic [IDX_W-1:0] rr_ptr, id_q, arb_idx, next_ptr;
    logic [N_REQ-1:0] arb_gnt, gnt_q;
    logic [WIDTH-1:0] len_q, arb_len;
    logic             load_job, adv_ptr, err_set;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req     (req),
        .pointer (rr_ptr),
        .grant   (arb_gnt),
        .index   (arb_idx)
    );

    assign arb_len  = req_len[arb_idx*WIDTH +: WIDTH];
    assign next_ptr = (id_q == IDX_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        ld_enb     = 1'b0;
        count_enb  = 1'b0;
        load_job   = 1'b0;
        adv_ptr    = 1'b0;
        err_set    = 1'b0;
        unique case (state)
            IDLE: begin
                if (|req) begin
                    load_job   = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                ld_enb = 1'b1;
                if (abort) begin
                    adv_ptr    = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = RUN;
                end
            end
            RUN: begin
                err_set = (count_out > len_q);
                if (abort) begin
                    adv_ptr    = 1'b1;
                    state_next = IDLE;
                end else if (count_out >= len_q) begin
                    state_next = DONE;
                end else begin
                    count_enb = 1'b1;
                end
            end
            DONE: begin
                adv_ptr    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rr_ptr <= '0;
            id_q   <= '0;
            len_q  <= '0;
            gnt_q  <= '0;
            err    <= 1'b0;
        end else begin
            state <= state_next;
            if (load_job) begin
                id_q  <= arb_idx;
                len_q <= arb_len;
                gnt_q <= arb_gnt;
            end
            if (adv_ptr) begin
                rr_ptr <= next_ptr;
            end
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

    // Every job starts the counter from zero.
    assign data_in = '0;
    assign busy    = (state != IDLE);
    assign gnt     = busy ? gnt_q : '0;
    assign ack     = (state == DONE) ? gnt_q : '0;

endmodule
